rw_ts_ram_master: RTL and testbench



---
 rtl/rw_ts_ram_pkg.sv | 21 ++
 rtl/ts_bus_drv.sv | 14 +
 rtl/rw_ts_ram_master.sv | 179 +++++++++++++++++
 tb/tb_rw_ts_ram_master.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rw_ts_ram_pkg.sv
// Shared types and default parameters for the time-sharing RAM bus master.
package rw_ts_ram_pkg;

  localparam int unsigned DefAw        = 4;
  localparam int unsigned DefDw        = 4;
  localparam int unsigned DefSetupCyc  = 1;
  localparam int unsigned DefStrobeCyc = 2;

  typedef enum logic [2:0] {
    StIdle,
    StWSetup,
    StWStrobe,
    StWHold,
    StRAcc,
`ifdef RW_TS_RAM_MASTER_VERIFY_EN
    StVAcc,
`endif
    StResp
  } state_e;

endpackage

// File: rtl/ts_bus_drv.sv
// DW-wide tristate driver; the only place the shared RAM data bus is driven.
module ts_bus_drv #(
  parameter int unsigned DW = 4
) (
  input  logic          oe_i,
  input  logic [DW-1:0] dout_i,
  output logic [DW-1:0] din_o,
  inout  wire  [DW-1:0] bus_io
);

  assign bus_io = oe_i ? dout_i : {DW{1'bz}};
  assign din_o  = bus_io;

endmodule

// File: rtl/rw_ts_ram_master.sv
// Bus master for the read/write time-sharing RAM. Converts single-beat valid/ready
// requests into addr/read/write strobes and owns turnaround of the shared data bus.
// Optional write-verify readback: define RW_TS_RAM_MASTER_VERIFY_EN.
module rw_ts_ram_master
  import rw_ts_ram_pkg::*;
#(
  parameter int unsigned AW         = DefAw,
  parameter int unsigned DW         = DefDw,
  parameter int unsigned SETUP_CYC  = DefSetupCyc,
  parameter int unsigned STROBE_CYC = DefStrobeCyc
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic [AW-1:0] ram_addr,
  output logic          ram_read,
  output logic          ram_write,
  inout  wire  [DW-1:0] ram_data
);

  localparam int unsigned AccCyc = SETUP_CYC + STROBE_CYC;
  localparam int unsigned CntW   = $clog2(AccCyc + 1);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);
  localparam logic [CntW-1:0] CntSetup  = CntW'(SETUP_CYC - 1);
  localparam logic [CntW-1:0] CntStrobe = CntW'(STROBE_CYC - 1);
  localparam logic [CntW-1:0] CntAcc    = CntW'(AccCyc - 1);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   rdata_q;
  logic            ram_read_q;
  logic            ram_write_q;
  logic            rsp_valid_q;
  logic [DW-1:0]   rsp_rdata_q;
  logic            bus_oe;
  logic [DW-1:0]   bus_din;
`ifdef RW_TS_RAM_MASTER_VERIFY_EN
  logic            err_q;
  logic            rsp_err_q;
`endif

  assign req_ready = rst_n && (state_q == StIdle);
  assign bus_oe    = (state_q == StWSetup) || (state_q == StWStrobe) || (state_q == StWHold);

  assign ram_addr  = addr_q;
  assign ram_read  = ram_read_q;
  assign ram_write = ram_write_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
`ifdef RW_TS_RAM_MASTER_VERIFY_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

  ts_bus_drv #(
    .DW(DW)
  ) u_bus_drv (
    .oe_i  (bus_oe),
    .dout_i(wdata_q),
    .din_o (bus_din),
    .bus_io(ram_data)
  );

  // Sequencer FSM; strobes and response are registered one cycle behind the state, so
  // ram_write rises a full cycle into WSTROBE with data already stable on the bus.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      ram_read_q  <= 1'b0;
      ram_write_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef RW_TS_RAM_MASTER_VERIFY_EN
      err_q       <= 1'b0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      ram_write_q <= (state_q == StWStrobe);
`ifdef RW_TS_RAM_MASTER_VERIFY_EN
      ram_read_q  <= (state_q == StRAcc) || (state_q == StVAcc);
      rsp_err_q   <= (state_q == StResp) ? err_q : 1'b0;
`else
      ram_read_q  <= (state_q == StRAcc);
`endif
      rsp_valid_q <= (state_q == StResp);
      rsp_rdata_q <= (state_q == StResp) ? rdata_q : '0;

      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rdata_q <= '0;
`ifdef RW_TS_RAM_MASTER_VERIFY_EN
            err_q   <= 1'b0;
`endif
            if (req_we) begin
              state_q <= StWSetup;
              cnt_q   <= CntSetup;
            end else begin
              state_q <= StRAcc;
              cnt_q   <= CntAcc;
            end
          end
        end
        StWSetup: begin
          if (cnt_q == '0) begin
            state_q <= StWStrobe;
            cnt_q   <= CntStrobe;
          end else begin
            cnt_q <= cnt_q - CntOne;
          end
        end
        StWStrobe: begin
          if (cnt_q == '0) begin
            state_q <= StWHold;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CntOne;
          end
        end
        StWHold: begin
`ifdef RW_TS_RAM_MASTER_VERIFY_EN
          state_q <= StVAcc;
          cnt_q   <= CntAcc;
`else
          state_q <= StResp;
          cnt_q   <= '0;
`endif
        end
        StRAcc: begin
          if (cnt_q == '0) begin
            // Raw capture: X/Z on the bus is passed to the requester untouched.
            rdata_q <= bus_din;
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q - CntOne;
          end
        end
`ifdef RW_TS_RAM_MASTER_VERIFY_EN
        StVAcc: begin
          if (cnt_q == '0) begin
            rdata_q <= bus_din;
            // if/else so an unknown compare result lands in the mismatch branch
            if (bus_din == wdata_q) err_q <= 1'b0;
            else                    err_q <= 1'b1;
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q - CntOne;
          end
        end
`endif
        StResp: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rw_ts_ram_master.sv
// Directed bench for rw_ts_ram_master with a behavioural 16x4 RAM on the shared bus.
// The data bus carries a pull-up, so a released bus reads back as all ones.
module tb_rw_ts_ram_master;

  localparam int unsigned S = 1;
  localparam int unsigned T = 2;
  localparam int RdLat = S + T + 1;
`ifdef RW_TS_RAM_MASTER_VERIFY_EN
  localparam int WrLat = 2 * (S + T) + 2;
`else
  localparam int WrLat = S + T + 2;
`endif
  localparam logic [3:0] BusRel = 4'b1111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_we;
  logic [3:0] req_addr;
  logic [3:0] req_wdata;
  wire        req_ready;
  wire        rsp_valid;
  wire  [3:0] rsp_rdata;
  wire        rsp_err;
  wire  [3:0] ram_addr;
  wire        ram_read;
  wire        ram_write;
  wire  [3:0] ram_data;

  int n_cmp = 0;
  int n_mis = 0;

  // Behavioural RAM: combinational read while ram_read, commit on rising ram_write.
  logic [3:0] mem [16];
  logic       stuck;
  logic       pl_go;
  logic [3:0] pl_addr;
  logic [3:0] pl_data;
  wire  [3:0] ram_rd = mem[ram_addr] & (stuck ? 4'b1110 : 4'b1111);

  pullup pu_data (ram_data);
  assign ram_data = ram_read ? ram_rd : 4'bzzzz;

  always @(posedge ram_write or posedge pl_go) begin
    if (pl_go) mem[pl_addr] <= pl_data;
    else       mem[ram_addr] <= ram_data;
  end

  always #5 clk = ~clk;

  rw_ts_ram_master dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .ram_addr (ram_addr),
    .ram_read (ram_read),
    .ram_write(ram_write),
    .ram_data (ram_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [3:0] a, input logic [3:0] d);
    pl_addr = a;
    pl_data = d;
    pl_go   = 1'b1;
    #1;
    pl_go   = 1'b0;
    #1;
  endtask

  // Issue one request from a negedge; returns at the negedge where rsp_valid is seen.
  task automatic run_req(input logic we, input logic [3:0] a, input logic [3:0] d,
                         output int lat, output logic [3:0] rd, output logic er,
                         output int rd_cyc, output int wr_cyc, output int wr_rise);
    int  w;
    bit  done;
    lat = -1; rd = '0; er = 1'b0; rd_cyc = 0; wr_cyc = 0; wr_rise = -1; done = 1'b0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("accept_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    for (int k = 0; k < 30 && !done; k++) begin
      @(negedge clk);
      if (k == 0) req_valid = 1'b0;
      if (ram_read) rd_cyc++;
      if (ram_write) begin
        wr_cyc++;
        if (wr_rise < 0) wr_rise = k;
      end
      chk("rd_wr_excl", {31'd0, ram_read & ram_write}, 32'd0);
      if (ram_read)                chk("bus_rd", {28'd0, ram_data}, {28'd0, ram_rd});
      else if (we && k <= S + T)   chk("bus_wr", {28'd0, ram_data}, {28'd0, d});
      else                         chk("bus_rel", {28'd0, ram_data}, {28'd0, BusRel});
      if (rsp_valid) begin
        lat = k; rd = rsp_rdata; er = rsp_err; done = 1'b1;
      end
    end
    chk("rsp_seen", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int lat, rc, wc, wr;
    int wk;
    logic [3:0] rd, d, exp_rd;
    logic er, we;
    logic [3:0] a;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    stuck = 1'b0; pl_go = 1'b0; pl_addr = '0; pl_data = '0;
    for (int i = 0; i < 16; i++) preload(4'(i), 4'(i));
    preload(4'd3, 4'b1010);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", {28'd0, rsp_rdata}, 32'd0);
    chk("rst_rsp_err",   {31'd0, rsp_err}, 32'd0);
    chk("rst_ram_addr",  {28'd0, ram_addr}, 32'd0);
    chk("rst_ram_read",  {31'd0, ram_read}, 32'd0);
    chk("rst_ram_write", {31'd0, ram_write}, 32'd0);
    chk("rst_ram_data",  {28'd0, ram_data}, {28'd0, BusRel});
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

    // Read after reset
    run_req(1'b0, 4'd3, 4'b0101, lat, rd, er, rc, wc, wr);
    chk("rd3_lat",    lat, RdLat);
    chk("rd3_rdcyc",  rc, S + T);
    chk("rd3_wrcyc",  wc, 0);
    chk("rd3_rdata",  {28'd0, rd}, 32'b1010);
    chk("rd3_err",    {31'd0, er}, 32'd0);

    // Write then read
    run_req(1'b1, 4'd5, 4'b0110, lat, rd, er, rc, wc, wr);
    chk("wr5_lat",    lat, WrLat);
    chk("wr5_rise",   wr, S + 1);
    chk("wr5_wrcyc",  wc, T);
`ifndef RW_TS_RAM_MASTER_VERIFY_EN
    chk("wr5_rdata",  {28'd0, rd}, 32'd0);
    chk("wr5_rdcyc",  rc, 0);
`endif
    chk("wr5_err",    {31'd0, er}, 32'd0);
    chk("wr5_mem",    {28'd0, mem[5]}, 32'b0110);
    run_req(1'b0, 4'd5, 4'b1001, lat, rd, er, rc, wc, wr);
    chk("rd5_rdata",  {28'd0, rd}, 32'b0110);

    // Back-to-back writes to 15 then 0 with req_valid held
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd15; req_wdata = 4'b0011;
    chk("b2b_ready0", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_addr = 4'd0; req_wdata = 4'b1100;
    wk = -1;
    for (int k = 0; k < 20 && wk < 0; k++) begin
      if (k > 0) @(negedge clk);
      if (req_ready) wk = k;
    end
    chk("b2b_second_ready", wk, WrLat);
    chk("b2b_rsp_with_ready", {31'd0, rsp_valid}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    wk = -1;
    for (int k = 0; k < 20 && wk < 0; k++) begin
      if (k > 0) @(negedge clk);
      if (rsp_valid) wk = k;
    end
    chk("b2b_second_lat", wk, WrLat);
    chk("b2b_mem15", {28'd0, mem[15]}, 32'b0011);
    chk("b2b_mem0",  {28'd0, mem[0]},  32'b1100);
    chk("b2b_mem14", {28'd0, mem[14]}, 32'd14);
    chk("b2b_mem1",  {28'd0, mem[1]},  32'd1);

    // Reset during WSTROBE, after the strobe has risen
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd7; req_wdata = 4'b1001;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mr_strobe_up", {31'd0, ram_write}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mr_strobe_down", {31'd0, ram_write}, 32'd0);
    chk("mr_read_low",    {31'd0, ram_read}, 32'd0);
    chk("mr_bus_rel",     {28'd0, ram_data}, {28'd0, BusRel});
    chk("mr_no_rsp",      {31'd0, rsp_valid}, 32'd0);
    chk("mr_ready_low",   {31'd0, req_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("mr_ready_back",  {31'd0, req_ready}, 32'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("mr_quiet_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    chk("mr_mem7", {28'd0, mem[7]}, 32'b1001);
    run_req(1'b0, 4'd7, 4'b0110, lat, rd, er, rc, wc, wr);
    chk("mr_rd7", {28'd0, rd}, 32'b1001);

`ifdef RW_TS_RAM_MASTER_VERIFY_EN
    // Write-verify: clean readback, then bit0 stuck at 0
    run_req(1'b1, 4'd2, 4'b1111, lat, rd, er, rc, wc, wr);
    chk("vf_lat",   lat, WrLat);
    chk("vf_err",   {31'd0, er}, 32'd0);
    chk("vf_rdata", {28'd0, rd}, 32'b1111);
    chk("vf_rdcyc", rc, S + T);
    stuck = 1'b1;
    run_req(1'b1, 4'd2, 4'b1111, lat, rd, er, rc, wc, wr);
    chk("vf_stuck_err",   {31'd0, er}, 32'd1);
    chk("vf_stuck_rdata", {28'd0, rd}, 32'b1110);
    stuck = 1'b0;
`endif

    // Random mixed traffic with bus and strobe exclusivity checks every cycle
    for (int i = 0; i < 200; i++) begin
      we = 1'($urandom_range(0, 1));
      a  = 4'($urandom_range(0, 15));
      exp_rd = mem[a];
      d  = we ? 4'($urandom_range(0, 14)) : ~exp_rd;
      run_req(we, a, d, lat, rd, er, rc, wc, wr);
      if (we) begin
        chk("rnd_wlat", lat, WrLat);
        chk("rnd_wmem", {28'd0, mem[a]}, {28'd0, d});
        chk("rnd_werr", {31'd0, er}, 32'd0);
      end else begin
        chk("rnd_rlat", lat, RdLat);
        chk("rnd_rdata", {28'd0, rd}, {28'd0, exp_rd});
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
